mem_fetch_unit: RTL and testbench
=================================

# mem_fetch_unit

Memory-access stage of the multicycle MIPS core. It turns the control FSM's memory strobes (instruction fetch, load, store) into a request/acknowledge transaction on a variable-latency memory port. It holds the Instruction Register, which feeds `Op`/`funct` upstream into the control unit, and the Memory Data Register. While a transaction is outstanding it asserts `stall`, and the control FSM holds its current state.

## Interface
- `DATA_W`, 32, data and instruction width
- `ADDR_W`, 32, byte-address width
- `TIMEOUT`, 15, maximum cycles to wait for `mem_ack` (only with `MEM_TIMEOUT_EN`)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `IRWrite`  in  1  instruction fetch request (address = `pc`)
- `MemWrite`  in  1  store request (address = `alu_out`)
- `MemRead`  in  1  load request (address = `alu_out`)
- `pc`  in  ADDR_W  program counter
- `alu_out`  in  ADDR_W  data address
- `wdata`  in  DATA_W  store data (rt)
- `mem_req`  out  1  memory request, registered
- `mem_we`  out  1  write qualifier
- `mem_addr`  out  ADDR_W  word-aligned address, bits [1:0] = 00
- `mem_wdata`  out  DATA_W  store data
- `mem_ack`  in  1  memory completion, one cycle per transaction
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`
- `instr`  out  DATA_W  Instruction Register
- `Op`  out  6  `instr[31:26]`
- `funct`  out  6  `instr[5:0]`
- `mdr`  out  DATA_W  Memory Data Register
- `stall`  out  1  control FSM hold
- `bus_err`  out  1  sticky timeout flag

## Operation
- `start` = (`IRWrite` | `MemWrite` | `MemRead`). Priority: `IRWrite` > `MemWrite` > `MemRead`. Lower-priority strobes asserted in the same cycle are ignored.
- States:
  - IDLE: on `start`, latch kind, address, `wdata`, and write flag; go to BUSY.
  - BUSY: `mem_req`=1. `mem_we`/`mem_addr`/`mem_wdata` are held stable. On `mem_ack`: a fetch loads `instr` from `mem_rdata`; a load loads `mdr` from `mem_rdata`; a store changes neither. Then `mem_req`→0 and the FSM goes to DONE.
  - DONE: lasts one cycle. `start` is ignored, because the control strobes are still high. Next state is IDLE.
- `stall` is combinational: (IDLE & `start`) | BUSY. It is 0 in DONE and 0 while `reset`=1.
- `mem_ack` in IDLE or DONE is ignored.
- `instr` and `mdr` hold their values between transactions.
- Reset values: `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `instr` 0 (so `Op`=0, `funct`=0), `mdr` 0, `bus_err` 0, state IDLE.
- Reset mid-transaction: `mem_req` drops at that edge, registers clear, and a later `mem_ack` is ignored.

## Timing
- Cycle T: IDLE with `start`, `stall`=1.
- T+1: first BUSY cycle, `mem_req`=1. `mem_ack` may arrive here at the earliest.
- Ack in cycle A: `instr`/`mdr` are updated at the end of A. Cycle A+1 is DONE with `stall`=0, and the control FSM advances at the end of A+1.
- Minimum access is 3 cycles, with zero memory wait states.
- The control FSM sees the new `Op`/`funct` from A+1 onward.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without `mem_ack`.
  - When the count reaches `TIMEOUT`: `mem_req`→0, `bus_err`←1 (sticky until `reset`), state→DONE, `instr`/`mdr` unchanged.
  - `mem_ack` in the same cycle as the limit wins; it is a normal completion.
- Not defined: no counter, BUSY waits indefinitely, `bus_err` tied 0.

## Structure
- Shared package `mips_mc_pkg`:
  - state encoding (IDLE/BUSY/DONE)
  - access-kind encoding (FETCH/LOAD/STORE)
  - opcode/funct field bit positions
- One sub-module: `bus_watchdog`, the timeout counter, instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- Reset, then `IRWrite`=1, `pc`=0x0000_0004, `mem_ack` at the first BUSY cycle with `mem_rdata`=0x2008_0005 → `mem_addr`=0x4, `mem_we`=0, `stall` high 2 cycles, then `instr`=0x2008_0005, `Op`=0x08.
- `MemWrite`=1, `alu_out`=0x0000_0013, `wdata`=0xDEAD_BEEF, `mem_ack` after 3 wait cycles → `mem_addr`=0x10, `mem_we`=1, `mem_wdata`=0xDEAD_BEEF stable throughout, `mdr`/`instr` unchanged.
- `IRWrite`=1 and `MemRead`=1 together, `pc`=0x8, `alu_out`=0x40 → fetch from 0x8 only; `mdr` unchanged.
- Reset asserted in the 2nd BUSY cycle, `mem_ack` one cycle later → `mem_req` 0 after the edge, `instr`=0, ack ignored, `stall`=0.
- `MEM_TIMEOUT_EN`, `TIMEOUT`=15, no ack → `mem_req` drops after 15 BUSY cycles, `bus_err`=1 sticky, one DONE cycle; the next fetch works normally with `bus_err` still 1.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS core: memory-stage FSM states,
// memory access kinds and instruction field positions.
package mips_mc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } access_kind_t;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // Fetch beats store beats load when the control FSM raises several strobes.
    function automatic access_kind_t select_kind(input logic ir_write,
                                                 input logic mem_write,
                                                 input logic mem_read);
        if (ir_write)
            return KIND_FETCH;
        else if (mem_write)
            return KIND_STORE;
        else if (mem_read)
            return KIND_LOAD;
        else
            return KIND_FETCH;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Timeout counter for an outstanding memory transaction; used by
// mem_fetch_unit only when MEM_TIMEOUT_EN is defined.
module bus_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Fires in the TIMEOUT-th busy cycle without an ack, so the request
    // is held for exactly TIMEOUT cycles.
    assign expired = busy && !ack && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || start)
            count <= '0;
        else if (busy && !ack && !expired)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_fetch_unit.sv
// Memory-access stage of the multicycle MIPS core: req/ack memory port,
// Instruction Register and Memory Data Register. Optional timeout: MEM_TIMEOUT_EN.
module mem_fetch_unit
    import mips_mc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IRWrite,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        Op,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              bus_err
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_fetch_unit: TIMEOUT must be at least 1");
    end

    logic [1:0]        state;
    access_kind_t      kind_q;
    access_kind_t      sel_kind;
    logic              start;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] aligned_addr;
    logic              timeout_hit;

    assign start        = IRWrite || MemWrite || MemRead;
    assign sel_kind     = select_kind(IRWrite, MemWrite, MemRead);
    assign sel_addr     = (sel_kind == KIND_FETCH) ? pc : alu_out;
    assign aligned_addr = sel_addr & {{(ADDR_W-2){1'b1}}, 2'b00};

    assign Op    = instr[OP_MSB:OP_LSB];
    assign funct = instr[FUNCT_MSB:FUNCT_LSB];

    // Held low during reset so the control FSM never sees a stall it cannot clear.
    assign stall = !reset && (((state == ST_IDLE) && start) || (state == ST_BUSY));

`ifdef MEM_TIMEOUT_EN
    logic enter_busy;

    assign enter_busy = (state == ST_IDLE) && start;

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_bus_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (enter_busy),
        .busy    (state == ST_BUSY),
        .ack     (mem_ack),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (reset)
            bus_err <= 1'b0;
        else if (timeout_hit)
            bus_err <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            kind_q    <= KIND_FETCH;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            instr     <= '0;
            mdr       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        kind_q    <= sel_kind;
                        mem_addr  <= aligned_addr;
                        mem_wdata <= wdata;
                        mem_we    <= (sel_kind == KIND_STORE);
                        mem_req   <= 1'b1;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // An ack in the limit cycle counts as a normal completion.
                    if (mem_ack) begin
                        if (kind_q == KIND_FETCH)
                            instr <= mem_rdata;
                        if (kind_q == KIND_LOAD)
                            mdr <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= ST_DONE;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Directed self-checking bench for mem_fetch_unit; the timeout scenario is
// exercised only when MEM_TIMEOUT_EN is defined.
module tb_mem_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        IRWrite, MemWrite, MemRead;
    logic [31:0] pc, alu_out, wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [5:0]  Op, funct;
    logic [31:0] mdr;
    logic        stall, bus_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_fetch_unit #(
        .DATA_W (32),
        .ADDR_W (32),
        .TIMEOUT(15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .IRWrite   (IRWrite),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .instr     (instr),
        .Op        (Op),
        .funct     (funct),
        .mdr       (mdr),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;

        reset = 1'b1; IRWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        pc = '0; alu_out = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        IRWrite = 1'b1; pc = 32'h0000_0004;
        tick();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_op", 32'(Op), 32'd0);
        check("rst_funct", 32'(funct), 32'd0);
        check("rst_mdr", mdr, 32'd0);
        check("rst_buserr", 32'(bus_err), 32'd0);

        // Fetch from 0x4, zero wait states
        reset = 1'b0;
        #1 check("f1_T_stall", 32'(stall), 32'd1);
        tick();
        check("f1_busy_req", 32'(mem_req), 32'd1);
        check("f1_busy_addr", mem_addr, 32'h0000_0004);
        check("f1_busy_we", 32'(mem_we), 32'd0);
        check("f1_busy_stall", 32'(stall), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        #1;
        check("f1_done_stall", 32'(stall), 32'd0);
        check("f1_done_req", 32'(mem_req), 32'd0);
        check("f1_instr", instr, 32'h2008_0005);
        check("f1_op", 32'(Op), 32'h08);
        check("f1_funct", 32'(funct), 32'h05);
        tick();
        IRWrite = 1'b0;
        #1 check("f1_idle_stall", 32'(stall), 32'd0);

        // Store to 0x13 -> 0x10, ack after 3 wait cycles
        MemWrite = 1'b1; alu_out = 32'h0000_0013; wdata = 32'hDEAD_BEEF;
        #1 check("st_T_stall", 32'(stall), 32'd1);
        tick();
        wdata = 32'h1234_5678; alu_out = 32'h0000_0FFC;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_wait_req", 32'(mem_req), 32'd1);
            check("st_wait_addr", mem_addr, 32'h0000_0010);
            check("st_wait_we", 32'(mem_we), 32'd1);
            check("st_wait_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_wait_stall", 32'(stall), 32'd1);
            tick();
        end
        check("st_ack_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("st_ack_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        mem_ack = 1'b0;
        #1;
        check("st_done_req", 32'(mem_req), 32'd0);
        check("st_done_stall", 32'(stall), 32'd0);
        check("st_instr", instr, 32'h2008_0005);
        check("st_mdr", mdr, 32'd0);
        tick();
        MemWrite = 1'b0;

        // IRWrite and MemRead together: fetch from 0x8 only
        IRWrite = 1'b1; MemRead = 1'b1; pc = 32'h0000_0008; alu_out = 32'h0000_0040;
        tick();
        check("pri_addr", mem_addr, 32'h0000_0008);
        check("pri_we", 32'(mem_we), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h012A_4020;
        tick();
        mem_ack = 1'b0;
        check("pri_instr", instr, 32'h012A_4020);
        check("pri_op", 32'(Op), 32'h00);
        check("pri_funct", 32'(funct), 32'h20);
        check("pri_mdr", mdr, 32'd0);
        tick();
        IRWrite = 1'b0; MemRead = 1'b0;

        // Load from 0x41 -> 0x40, one wait state
        MemRead = 1'b1; alu_out = 32'h0000_0041;
        tick();
        check("ld_addr", mem_addr, 32'h0000_0040);
        check("ld_we", 32'(mem_we), 32'd0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check("ld_mdr", mdr, 32'hCAFE_F00D);
        check("ld_instr", instr, 32'h012A_4020);
        check("ld_done_stall", 32'(stall), 32'd0);
        tick();
        MemRead = 1'b0;
        // Stray ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_instr", instr, 32'h012A_4020);
        check("idle_ack_mdr", mdr, 32'hCAFE_F00D);
        check("idle_ack_req", 32'(mem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // No ack: request held for exactly 15 cycles
        IRWrite = 1'b1; pc = 32'h0000_0100;
        tick();
        cyc = 0;
        while (mem_req === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
        check("to_busy_cycles", 32'(cyc), 32'd15);
        check("to_req", 32'(mem_req), 32'd0);
        check("to_buserr", 32'(bus_err), 32'd1);
        check("to_done_stall", 32'(stall), 32'd0);
        check("to_instr", instr, 32'h012A_4020);
        check("to_mdr", mdr, 32'hCAFE_F00D);
        tick();
        IRWrite = 1'b0;
        #1 check("to_idle_stall", 32'(stall), 32'd0);
        IRWrite = 1'b1; pc = 32'h0000_0104;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h8C09_0004;
        tick();
        mem_ack = 1'b0;
        check("to_next_instr", instr, 32'h8C09_0004);
        check("to_next_op", 32'(Op), 32'h23);
        check("to_sticky", 32'(bus_err), 32'd1);
        tick();
        IRWrite = 1'b0;
`else
        check("no_to_buserr", 32'(bus_err), 32'd0);
        cyc = 0;
`endif

        // Reset in the 2nd BUSY cycle, ack one cycle later
        IRWrite = 1'b1; pc = 32'h0000_000C;
        tick();
        tick();
        check("rm_busy2_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1 check("rm_rst_stall", 32'(stall), 32'd0);
        tick();
        check("rm_req", 32'(mem_req), 32'd0);
        check("rm_instr", instr, 32'd0);
        check("rm_mdr", mdr, 32'd0);
        check("rm_buserr", 32'(bus_err), 32'd0);
        reset = 1'b0; IRWrite = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1 check("rm_ack_stall", 32'(stall), 32'd0);
        tick();
        mem_ack = 1'b0;
        check("rm_after_instr", instr, 32'd0);
        check("rm_after_req", 32'(mem_req), 32'd0);
        check("rm_after_stall", 32'(stall), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
